// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// instruction field constants, ALU and mux select codes, and the bundle of
// datapath control signals produced by the output decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_J      = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_FAULT  = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand selects and PC source selects
  localparam logic       ASEL_PC    = 1'b0;
  localparam logic       ASEL_A     = 1'b1;
  localparam logic [1:0] BSEL_B     = 2'b00;
  localparam logic [1:0] BSEL_4     = 2'b01;
  localparam logic [1:0] BSEL_SEXT  = 2'b10;
  localparam logic [1:0] BSEL_SEXT2 = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_JUMP    = 2'b01;
  localparam logic [1:0] PC_ALUOUT  = 2'b10;
  localparam logic [1:0] PC_A       = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       asel;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ld_ir;
    logic       mem_or_i;
    logic       wr31;
    logic       wrdmux;
    logic [1:0] bsel;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       fault;
  } ctrl_t;

  // True for the R-type function codes the ALU supports.
  function automatic logic func_known(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // ALU code for an R-type function; unsupported codes map to 000.
  function automatic logic [2:0] func_alu(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decoder: maps the current state (plus func for R-type
// execute and mem_ack for the fetch-completion cycle) onto the control bundle.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  func,
  input  logic        mem_ack,
  output ctrl_t       ctrl
);

  // Per-state control values; everything not named for a state stays 0.
  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl.ld_ir    = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.asel     = ASEL_PC;
          ctrl.bsel     = BSEL_4;
          ctrl.alu_ctrl = ALU_ADD;
          ctrl.pc_src   = PC_ALU;
        end
      end
      S_DECODE: begin
        ctrl.asel     = ASEL_PC;
        ctrl.bsel     = BSEL_SEXT2;
        ctrl.alu_ctrl = ALU_ADD;
      end
      S_MEMADR, S_IEX: begin
        ctrl.asel     = ASEL_A;
        ctrl.bsel     = BSEL_SEXT;
        ctrl.alu_ctrl = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_or_i = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.mem_or_i = 1'b1;
      end
      S_REX: begin
        ctrl.asel     = ASEL_A;
        ctrl.bsel     = BSEL_B;
        ctrl.alu_ctrl = func_alu(func);
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IWB: ctrl.reg_write = 1'b1;
      S_BEQ: begin
        ctrl.asel          = ASEL_A;
        ctrl.bsel          = BSEL_B;
        ctrl.alu_ctrl      = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
      end
      S_J: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
      end
      S_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.wr31      = 1'b1;
        ctrl.wrdmux    = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_JUMP;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_A;
      end
      S_FAULT: ctrl.fault = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control unit with a req/ack memory handshake, a per-request
// timeout, a sticky fault state and a retired-instruction counter.
module mc_ctrl_hs
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             Asel,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             ld_IR,
  output logic             Mem_or_I,
  output logic             wr31,
  output logic             wrdmux,
  output logic [1:0]       Bsel,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t          state_q;
  logic [31:0]     wait_cnt;
  logic [CNT_W-1:0] retired_q;
  ctrl_t           ctrl;
  logic            is_req;
  logic            timed_out;
  logic            done;

  // The branch outcome is resolved in the datapath via PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  // Request-state, timeout and instruction-completion qualifiers.
  always_comb begin
    is_req    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timed_out = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));
    done      = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_IWB) ||
                (state_q == S_BEQ)   || (state_q == S_J)   || (state_q == S_JAL) ||
                (state_q == S_JR)    || ((state_q == S_MEMWR) && mem_ack);
  end

  // FSM: next state, request wait counter and retired counter.
  // NOTE: reset is asynchronous; it forces FETCH even in the middle of a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (done) retired_q <= retired_q + CNT_W'(1);

      // Counter is zero on entry to any request state and counts missed acks.
      if (is_req && !mem_ack) wait_cnt <= wait_cnt + 32'd1;
      else                    wait_cnt <= '0;

      case (state_q)
        S_FETCH:
          if (mem_ack)        state_q <= S_DECODE;
          else if (timed_out) state_q <= S_FAULT;
        S_DECODE:
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= (func == FN_JR) ? S_JR : S_REX;
            OP_BEQ:       state_q <= S_BEQ;
            OP_J:         state_q <= S_J;
            OP_JAL:       state_q <= S_JAL;
            OP_ADDI:      state_q <= S_IEX;
            default:      state_q <= S_FAULT;
          endcase
        S_MEMADR:
          if (opcode == OP_LW)      state_q <= S_MEMRD;
          else if (opcode == OP_SW) state_q <= S_MEMWR;
          else                      state_q <= S_FAULT;
        S_MEMRD:
          if (mem_ack)        state_q <= S_MEMWB;
          else if (timed_out) state_q <= S_FAULT;
        S_MEMWR:
          if (mem_ack)        state_q <= S_FETCH;
          else if (timed_out) state_q <= S_FAULT;
        S_REX:   state_q <= func_known(func) ? S_RWB : S_FAULT;
        S_IEX:   state_q <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BEQ, S_J, S_JAL, S_JR:
                 state_q <= S_FETCH;
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_FAULT;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state   (state_q),
    .func    (func),
    .mem_ack (mem_ack),
    .ctrl    (ctrl)
  );

  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_write   = ctrl.reg_write;
  assign Asel        = ctrl.asel;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign ld_IR       = ctrl.ld_ir;
  assign Mem_or_I    = ctrl.mem_or_i;
  assign wr31        = ctrl.wr31;
  assign wrdmux      = ctrl.wrdmux;
  assign Bsel        = ctrl.bsel;
  assign pc_src      = ctrl.pc_src;
  assign alu_ctrl    = ctrl.alu_ctrl;
  assign fault       = ctrl.fault;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: instruction-level model expands each instruction into
// its expected per-cycle trace; every cycle of the trace is compared.
module tb_mc_ctrl_hs;
  import mc_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, reg_dst, mem_to_reg, reg_write, Asel;
  logic        PCWrite, PCWriteCond, ld_IR, Mem_or_I, wr31, wrdmux, fault;
  logic [1:0]  Bsel, pc_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] retired;
  logic [3:0]  state;

  always #5 clk = ~clk;

  mc_ctrl_hs #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .Asel(Asel), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ld_IR(ld_IR),
    .Mem_or_I(Mem_or_I), .wr31(wr31), .wrdmux(wrdmux), .Bsel(Bsel),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .fault(fault), .retired(retired),
    .state(state)
  );

  typedef struct packed {
    logic       mem_req, mem_we, reg_dst, mem_to_reg, reg_write, asel;
    logic       pc_write, pc_write_cond, ld_ir, mem_or_i, wr31, wrdmux;
    logic [1:0] bsel, pc_src;
    logic [2:0] alu;
    logic       fault;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        ack;
    exp_t        e;
    state_t      st;
    logic [31:0] ret;
  } cyc_t;

  exp_t act;
  assign act = {mem_req, mem_we, reg_dst, mem_to_reg, reg_write, Asel,
                PCWrite, PCWriteCond, ld_IR, Mem_or_I, wr31, wrdmux,
                Bsel, pc_src, alu_ctrl, fault};

  cyc_t        q[$];
  logic [5:0]  cur_op, cur_fn;
  logic        stray;
  logic [31:0] ret_m;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic push(input state_t st, input logic ack, input exp_t e);
    cyc_t r;
    r.op = cur_op; r.fn = cur_fn; r.ack = ack; r.e = e; r.st = st; r.ret = ret_m;
    q.push_back(r);
  endtask

  task automatic fault_hold(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.fault = 1'b1;
      push(S_FAULT, i[0], e);   // acks here must be ignored
    end
  endtask

  // Request phase: 'waits' cycles without ack; TMO misses end in FAULT.
  task automatic wait_phase(input state_t st, input exp_t e, input int waits, output bit ok);
    ok = (waits < TMO);
    for (int i = 0; i < waits && i < TMO; i++) push(st, 1'b0, e);
    if (!ok) fault_hold(3);
  endtask

  // Expected trace of one instruction: fw/mw are missed-ack cycles before ack.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    exp_t e; bit ok; logic [2:0] alu; bit known;
    cur_op = op; cur_fn = fn;
    e = '0; e.mem_req = 1'b1;
    wait_phase(S_FETCH, e, fw, ok);
    if (!ok) return;
    e.ld_ir = 1'b1; e.pc_write = 1'b1; e.bsel = 2'b01; e.alu = 3'b010;
    push(S_FETCH, 1'b1, e);
    e = '0; e.bsel = 2'b11; e.alu = 3'b010;
    push(S_DECODE, stray, e);
    e = '0;
    case (op)
      6'd35, 6'd43: begin
        e.asel = 1'b1; e.bsel = 2'b10; e.alu = 3'b010;
        push(S_MEMADR, stray, e);
        e = '0; e.mem_req = 1'b1; e.mem_or_i = 1'b1; e.mem_we = (op == 6'd43);
        wait_phase((op == 6'd35) ? S_MEMRD : S_MEMWR, e, mw, ok);
        if (!ok) return;
        push((op == 6'd35) ? S_MEMRD : S_MEMWR, 1'b1, e);
        if (op == 6'd35) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          push(S_MEMWB, stray, e);
        end
      end
      6'd0: begin
        if (fn == 6'd8) begin
          e.pc_write = 1'b1; e.pc_src = 2'b11;
          push(S_JR, stray, e);
        end else begin
          known = 1'b1;
          case (fn)
            6'd32:   alu = 3'b010;
            6'd34:   alu = 3'b110;
            6'd36:   alu = 3'b000;
            6'd37:   alu = 3'b001;
            6'd42:   alu = 3'b111;
            default: begin alu = 3'b000; known = 1'b0; end
          endcase
          e.asel = 1'b1; e.bsel = 2'b00; e.alu = alu;
          push(S_REX, stray, e);
          if (!known) begin fault_hold(3); return; end
          e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
          push(S_RWB, stray, e);
        end
      end
      6'd4: begin
        e.asel = 1'b1; e.alu = 3'b110; e.pc_write_cond = 1'b1; e.pc_src = 2'b10;
        push(S_BEQ, stray, e);
      end
      6'd2: begin
        e.pc_write = 1'b1; e.pc_src = 2'b01;
        push(S_J, stray, e);
      end
      6'd3: begin
        e.reg_write = 1'b1; e.wr31 = 1'b1; e.wrdmux = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b01;
        push(S_JAL, stray, e);
      end
      6'd8: begin
        e.asel = 1'b1; e.bsel = 2'b10; e.alu = 3'b010;
        push(S_IEX, stray, e);
        e = '0; e.reg_write = 1'b1;
        push(S_IWB, stray, e);
      end
      default: begin fault_hold(3); return; end
    endcase
    ret_m = ret_m + 32'd1;
  endtask

  // Plays the queued trace: drive at posedge+1, compare at negedge.
  task automatic run_q();
    foreach (q[i]) begin
      opcode = q[i].op; func = q[i].fn; mem_ack = q[i].ack;
      @(negedge clk);
      check($sformatf("cyc%0d ctrl", cyc), 32'(act), 32'(q[i].e));
      check($sformatf("cyc%0d state", cyc), 32'(state), 32'(q[i].st));
      check($sformatf("cyc%0d retired", cyc), retired, q[i].ret);
      cyc++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; ret_m = '0; stray = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    check("reset state", 32'(state), 32'(S_FETCH));
    check("reset mem_req", 32'(mem_req), 32'd1);
    check("reset retired", retired, 32'd0);
    check("reset fault", 32'(fault), 32'd0);

    // lw: 3 missed acks in FETCH and in MEMRD
    instr(6'd35, 6'd0, 3, 3);
    run_q();
    check("lw retired", retired, 32'd1);

    // add then beq
    do_reset();
    instr(6'd0, 6'd32, 0, 0);
    instr(6'd4, 6'd0, 1, 0);
    run_q();
    check("add+beq retired", retired, 32'd2);

    // Remaining instruction mix with stray acks in non-request states
    stray = 1'b1;
    instr(6'd43, 6'd0, 0, 2);
    instr(6'd0, 6'd34, 0, 0);
    instr(6'd0, 6'd36, 2, 0);
    instr(6'd0, 6'd37, 0, 0);
    instr(6'd0, 6'd42, 0, 0);
    instr(6'd8, 6'd0, 0, 0);
    instr(6'd2, 6'd0, 0, 0);
    instr(6'd3, 6'd0, 0, 0);
    instr(6'd0, 6'd8, 0, 0);
    run_q();
    check("mix retired", retired, 32'd11);

    // Ack on the last allowed cycle of FETCH and of MEMWR is honoured
    stray = 1'b0;
    instr(6'd2, 6'd0, TMO - 1, 0);
    instr(6'd43, 6'd0, 0, TMO - 1);
    run_q();
    check("late ack fault", 32'(fault), 32'd0);
    check("late ack retired", retired, 32'd13);

    // No ack in FETCH: fault after TMO cycles, sticky
    do_reset();
    instr(6'd35, 6'd0, TMO, 0);
    run_q();
    check("fetch timeout fault", 32'(fault), 32'd1);
    check("fetch timeout state", 32'(state), 32'(S_FAULT));

    // No ack in MEMRD
    do_reset();
    instr(6'd35, 6'd0, 0, TMO);
    run_q();
    check("memrd timeout fault", 32'(fault), 32'd1);

    // Illegal opcode and unknown R-type func
    do_reset();
    instr(6'd63, 6'd0, 0, 0);
    run_q();
    check("op63 fault", 32'(fault), 32'd1);
    do_reset();
    instr(6'd0, 6'd5, 0, 0);
    run_q();
    check("bad func fault", 32'(fault), 32'd1);

    // Asynchronous reset in the middle of a MEMWR wait
    do_reset();
    instr(6'd2, 6'd0, 0, 0);
    instr(6'd43, 6'd0, 0, 3);
    void'(q.pop_back());       // drop the ack cycle: reset lands mid-wait
    run_q();
    check("pre-reset retired", retired, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst state", 32'(state), 32'(S_FETCH));
    check("async rst retired", retired, 32'd0);
    check("async rst fault", 32'(fault), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    ret_m = '0;
    #1;
    check("post rst mem_req", 32'(mem_req), 32'd1);
    instr(6'd2, 6'd0, 0, 0);
    run_q();
    check("post rst retired", retired, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_hs.md
MC_CTRL_HS -- requirements
Module: mc_ctrl_hs

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles a memory request waits for mem_ack; 0 disables the timeout.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have ports: opcode input 6, IR[31:26]; func input 6, IR[5:0]; zero input 1, ALU zero flag (informational only).
REQ-005 SHALL have ports: mem_req output 1, memory request; mem_we output 1, write qualifier; mem_ack input 1, memory completion.
REQ-006 SHALL have datapath control outputs of width 1: reg_dst, mem_to_reg, reg_write, Asel, PCWrite, PCWriteCond, ld_IR, Mem_or_I, wr31, wrdmux.
REQ-007 SHALL have datapath control outputs Bsel (2), pc_src (2) and alu_ctrl (3).
REQ-008 SHALL have ports: fault output 1, sticky error; retired output CNT_W, count of completed instructions; state output 4, current state for debug.

Function
REQ-009 SHALL implement a Moore/Mealy FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, J, JAL, JR and FAULT.
REQ-010 SHALL drive every control output to 0 in any state and cycle not listed below.
REQ-011 Encodings: Asel 0=PC, 1=A; Bsel 00=B, 01=4, 10=sext, 11=sext<<2; pc_src 00=ALU, 01=jump, 10=ALUout, 11=A; alu_ctrl 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 FETCH SHALL assert mem_req with Mem_or_I=0; in the mem_ack cycle it SHALL also assert ld_IR, PCWrite, Asel=0, Bsel=01, add, pc_src=00, then go to DECODE; otherwise it holds.
REQ-013 DECODE SHALL drive Asel=0, Bsel=11, add, then dispatch: opcode 35 or 43 to MEMADR; 0 with func 8 to JR; 0 with any other func to REX; 4 to BEQ; 2 to J; 3 to JAL; 8 to IEX; any other opcode to FAULT.
REQ-014 MEMADR SHALL drive Asel=1, Bsel=10, add, then go to MEMRD for opcode 35 or MEMWR for opcode 43.
REQ-015 MEMRD SHALL assert mem_req with Mem_or_I=1 and go to MEMWB on mem_ack; memory data SHALL be valid in the ack cycle.
REQ-016 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-017 MEMWR SHALL assert mem_req, mem_we and Mem_or_I=1, and go to FETCH on mem_ack.
REQ-018 REX SHALL drive Asel=1, Bsel=00 and alu_ctrl from func (32 add, 34 sub, 36 and, 37 or, 42 slt); an unknown func SHALL go to FAULT, otherwise to RWB.
REQ-019 RWB SHALL drive reg_write=1 and reg_dst=1; IEX SHALL drive Asel=1, Bsel=10, add; IWB SHALL drive reg_write=1 and reg_dst=0.
REQ-020 BEQ SHALL drive Asel=1, Bsel=00, sub, PCWriteCond=1, pc_src=10; J SHALL drive PCWrite=1, pc_src=01; JR SHALL drive PCWrite=1, pc_src=11.
REQ-021 JAL SHALL drive reg_write, wr31, wrdmux, PCWrite and pc_src=01 all to 1/01 in the same cycle.
REQ-022 MEMWB, MEMWR, RWB, IWB, BEQ, J, JAL and JR SHALL each return to FETCH after completion.
REQ-023 retired SHALL increment by 1 (wrapping modulo 2^CNT_W) on the completing cycle of each instruction.
REQ-024 Timeout: a wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each waiting cycle without ack; with TIMEOUT>0, reaching TIMEOUT without ack SHALL go to FAULT.
REQ-025 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL be honoured (no fault).
REQ-026 FAULT SHALL assert fault=1 and hold all other outputs at 0 until reset; mem_ack arriving outside a request state SHALL be ignored.

Reset
REQ-027 rst SHALL asynchronously force state=FETCH, retired=0, fault=0 and the wait counter to 0, including mid-request; mem_req SHALL be 1 in the first cycle after release.

Structure
REQ-028 A shared package mc_pkg SHALL hold the state enum, opcode/func constants, alu_ctrl codes and Bsel/pc_src encodings.
REQ-029 Output decode SHALL be a single sub-module mc_ctrl_decode, purely combinational, mapping state, func and mem_ack to the control outputs.

Verification
REQ-030 lw with ack after 3 wait cycles -> FETCH(4)/DECODE/MEMADR/MEMRD(4)/MEMWB, reg_write with mem_to_reg=1, retired=1.
REQ-031 add (opcode 0, func 32) then beq taken -> RWB reg_dst=1; BEQ PCWriteCond=1, alu_ctrl=110, pc_src=10; retired=2.
REQ-032 jal -> one cycle with wr31=wrdmux=reg_write=PCWrite=1, pc_src=01; jr (func 8) -> pc_src=11.
REQ-033 TIMEOUT=16, no ack in FETCH -> fault=1 after cycle 16 and stays; ack exactly on cycle 16 -> no fault.
REQ-034 opcode 63 -> FAULT after DECODE; rst asserted mid-MEMWR -> immediate FETCH, retired=0, mem_req=1 after release.
